// File: rtl/hs_npu_layer_scheduler.sv
// Layer descriptor queue for the NPU: buffers CPU-written descriptors and issues them one at a
// time over the exec handshake, with completion counting, drain interrupt and per-layer watchdog.
module hs_npu_layer_scheduler #(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [31:0]                      cmd_num_input_rows_i,
  input  logic [31:0]                      cmd_num_input_columns_i,
  input  logic [31:0]                      cmd_num_weight_rows_i,
  input  logic [31:0]                      cmd_num_weight_columns_i,
  input  logic                             cmd_reuse_inputs_i,
  input  logic                             cmd_reuse_weights_i,
  input  logic                             cmd_save_outputs_i,
  input  logic                             cmd_use_bias_i,
  input  logic                             cmd_use_sum_i,
  input  logic                             cmd_activation_select_i,
  input  logic [31:0]                      cmd_shift_amount_i,
  input  logic [31:0]                      cmd_base_address_i,
  input  logic [31:0]                      cmd_result_address_i,
  output logic                             exec_valid_o,
  input  logic                             exec_ready_i,
  output logic [31:0]                      num_input_rows_o,
  output logic [31:0]                      num_input_columns_o,
  output logic [31:0]                      num_weight_rows_o,
  output logic [31:0]                      num_weight_columns_o,
  output logic                             reuse_inputs_o,
  output logic                             reuse_weights_o,
  output logic                             save_outputs_o,
  output logic                             use_bias_o,
  output logic                             use_sum_o,
  output logic                             activation_select_o,
  output logic [31:0]                      shift_amount_o,
  output logic [31:0]                      base_address_o,
  output logic [31:0]                      result_address_o,
  input  logic                             layer_done_i,
  input  logic                             flush_i,
  input  logic                             clear_error_i,
  output logic                             busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count_o,
  output logic [31:0]                      layers_done_o,
  output logic                             irq_o,
  output logic                             error_o
);

  localparam int unsigned PtrW       = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned WdLimitInt = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [31:0] WdLimit    = 32'(WdLimitInt);

  typedef struct packed {
    logic [31:0] num_input_rows;
    logic [31:0] num_input_columns;
    logic [31:0] num_weight_rows;
    logic [31:0] num_weight_columns;
    logic        reuse_inputs;
    logic        reuse_weights;
    logic        save_outputs;
    logic        use_bias;
    logic        use_sum;
    logic        activation_select;
    logic [31:0] shift_amount;
    logic [31:0] base_address;
    logic [31:0] result_address;
  } desc_t;

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StError} state_e;

  state_e            state_q, state_d;
  desc_t             queue_q [QUEUE_DEPTH];
  desc_t             cmd_desc, head;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       wd_q, layers_done_q;
  logic              irq_q;
  logic              full, push, pop, queue_clear, avail, wd_expire, run_done;

  assign cmd_desc = '{
    num_input_rows:     cmd_num_input_rows_i,
    num_input_columns:  cmd_num_input_columns_i,
    num_weight_rows:    cmd_num_weight_rows_i,
    num_weight_columns: cmd_num_weight_columns_i,
    reuse_inputs:       cmd_reuse_inputs_i,
    reuse_weights:      cmd_reuse_weights_i,
    save_outputs:       cmd_save_outputs_i,
    use_bias:           cmd_use_bias_i,
    use_sum:            cmd_use_sum_i,
    activation_select:  cmd_activation_select_i,
    shift_amount:       cmd_shift_amount_i,
    base_address:       cmd_base_address_i,
    result_address:     cmd_result_address_i
  };

  assign full        = (count_q == CntW'(QUEUE_DEPTH));
  // flush discards a same-cycle push, so it never lands in the queue
  assign push        = cmd_valid_i && cmd_ready_o && !flush_i;
  assign pop         = exec_valid_o && exec_ready_i;
  assign queue_clear = flush_i || (state_q == StError && clear_error_i);
  assign avail       = (count_q != '0) && !flush_i;
  assign run_done    = (state_q == StRun) && layer_done_i;
  assign wd_expire   = (TIMEOUT_CYCLES != 0) && (state_q == StRun) && (wd_q == WdLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (avail) state_d = StIssue;
      StIssue: begin
        if (pop) state_d = StRun;
        else if (flush_i) state_d = StIdle;
      end
      StRun: begin
        // completion wins over a coincident watchdog expiry
        if (layer_done_i) state_d = avail ? StIssue : StIdle;
        else if (wd_expire) state_d = StError;
      end
      StError: if (clear_error_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    exec_valid_o = (state_q == StIssue);
    busy_o       = (state_q == StIssue) || (state_q == StRun);
    error_o      = (state_q == StError);
    cmd_ready_o  = !full && (state_q != StError);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= '0;
    end else if (queue_clear) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) begin
        queue_q[wr_ptr_q] <= cmd_desc;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q          <= '0;
      layers_done_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      wd_q          <= (state_q == StRun) ? wd_q + 32'd1 : '0;
      irq_q         <= run_done && !avail;
      if (run_done) layers_done_q <= layers_done_q + 32'd1;
    end
  end

  assign head                 = queue_q[rd_ptr_q];
  assign num_input_rows_o     = head.num_input_rows;
  assign num_input_columns_o  = head.num_input_columns;
  assign num_weight_rows_o    = head.num_weight_rows;
  assign num_weight_columns_o = head.num_weight_columns;
  assign reuse_inputs_o       = head.reuse_inputs;
  assign reuse_weights_o      = head.reuse_weights;
  assign save_outputs_o       = head.save_outputs;
  assign use_bias_o           = head.use_bias;
  assign use_sum_o            = head.use_sum;
  assign activation_select_o  = head.activation_select;
  assign shift_amount_o       = head.shift_amount;
  assign base_address_o       = head.base_address;
  assign result_address_o     = head.result_address;
  assign queue_count_o        = count_q;
  assign layers_done_o        = layers_done_q;
  assign irq_o                = irq_q;

endmodule

// File: tb/tb_hs_npu_layer_scheduler.sv
// Directed bench for hs_npu_layer_scheduler: queueing, issue order, flush, watchdog and reset.
module tb_hs_npu_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] c_rows, c_cols, c_wrows, c_wcols, c_shift, c_base, c_result;
  logic        c_ri, c_rw, c_so, c_ub, c_us, c_act;
  logic        exec_valid, exec_ready;
  logic [31:0] rows, cols, wrows, wcols, shift, base, result;
  logic        ri, rw, so, ub, us, act;
  logic        layer_done, flush, clear_error, busy, irq, error;
  logic [2:0]  qcount;
  logic [31:0] layers_done;

  int total = 0;
  int bad   = 0;

  hs_npu_layer_scheduler #(.QUEUE_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_num_input_rows_i(c_rows), .cmd_num_input_columns_i(c_cols),
    .cmd_num_weight_rows_i(c_wrows), .cmd_num_weight_columns_i(c_wcols),
    .cmd_reuse_inputs_i(c_ri), .cmd_reuse_weights_i(c_rw), .cmd_save_outputs_i(c_so),
    .cmd_use_bias_i(c_ub), .cmd_use_sum_i(c_us), .cmd_activation_select_i(c_act),
    .cmd_shift_amount_i(c_shift), .cmd_base_address_i(c_base),
    .cmd_result_address_i(c_result),
    .exec_valid_o(exec_valid), .exec_ready_i(exec_ready),
    .num_input_rows_o(rows), .num_input_columns_o(cols),
    .num_weight_rows_o(wrows), .num_weight_columns_o(wcols),
    .reuse_inputs_o(ri), .reuse_weights_o(rw), .save_outputs_o(so),
    .use_bias_o(ub), .use_sum_o(us), .activation_select_o(act),
    .shift_amount_o(shift), .base_address_o(base), .result_address_o(result),
    .layer_done_i(layer_done), .flush_i(flush), .clear_error_i(clear_error),
    .busy_o(busy), .queue_count_o(qcount), .layers_done_o(layers_done),
    .irq_o(irq), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [31:0] b, input logic [31:0] r);
    c_base   = b;
    c_rows   = r;
    c_cols   = 32'd8;
    c_result = b + 32'h100;
    c_act    = b[0];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, exec_valid}, 0);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 1);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_irq"}, {31'd0, irq}, 0);
    chk({tag, "_err"}, {31'd0, error}, 0);
    chk({tag, "_count"}, {29'd0, qcount}, 0);
    chk({tag, "_layers"}, layers_done, 0);
    chk({tag, "_base"}, base, 0);
    chk({tag, "_rows"}, rows, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 0; exec_ready = 0; layer_done = 0; flush = 0; clear_error = 0;
    c_wrows = 32'd4; c_wcols = 32'd4; c_shift = 32'd3;
    c_ri = 0; c_rw = 1; c_so = 1; c_ub = 0; c_us = 1;
    set_cmd(32'h0, 32'h0);
    repeat (2) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // single layer
    set_cmd(32'h1000, 32'd8); cmd_valid = 1;
    tick(); cmd_valid = 0;
    chk("t1_count", {29'd0, qcount}, 1);
    chk("t1_novalid", {31'd0, exec_valid}, 0);
    exec_ready = 1;
    tick();
    chk("t1_valid", {31'd0, exec_valid}, 1);
    chk("t1_base", base, 32'h1000);
    chk("t1_rows", rows, 32'd8);
    chk("t1_result", result, 32'h1100);
    tick();
    chk("t1_valid_drop", {31'd0, exec_valid}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_count0", {29'd0, qcount}, 0);
    layer_done = 1; tick(); layer_done = 0;
    chk("t1_irq", {31'd0, irq}, 1);
    chk("t1_layers", layers_done, 1);
    chk("t1_idle", {31'd0, busy}, 0);
    tick();
    chk("t1_irq_pulse", {31'd0, irq}, 0);

    // fill the queue while the NPU stalls
    exec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(32'h2000 + 32'(i), 32'(i + 1)); cmd_valid = 1;
      tick();
    end
    chk("t2_count4", {29'd0, qcount}, 4);
    chk("t2_ready0", {31'd0, cmd_ready}, 0);
    chk("t2_head", base, 32'h2000);
    set_cmd(32'h8888, 32'd9);
    tick();
    chk("t2_full_count", {29'd0, qcount}, 4);
    chk("t2_head_stable", base, 32'h2000);
    chk("t2_rows_stable", rows, 32'd1);
    set_cmd(32'h9999, 32'd9); exec_ready = 1;
    tick(); cmd_valid = 0;
    chk("t2_full_pop_count", {29'd0, qcount}, 3);
    chk("t2_run", {31'd0, busy & ~exec_valid}, 1);
    for (int k = 1; k <= 3; k++) begin
      layer_done = 1; tick(); layer_done = 0;
      chk("t2_b2b_valid", {31'd0, exec_valid}, 1);
      chk("t2_order", base, 32'h2000 + 32'(k));
      chk("t2_layers", layers_done, 32'(1 + k));
      chk("t2_noirq", {31'd0, irq}, 0);
      tick();
      chk("t2_count", {29'd0, qcount}, 32'(3 - k));
    end
    layer_done = 1; tick(); layer_done = 0;
    chk("t2_irq", {31'd0, irq}, 1);
    chk("t2_layers5", layers_done, 5);
    tick();
    chk("t2_refused", {31'd0, exec_valid}, 0);
    chk("t2_empty", {29'd0, qcount}, 0);

    // same-cycle push/pop at count=2, then flush while running
    exec_ready = 0;
    set_cmd(32'h3000, 32'd1); cmd_valid = 1; tick();
    set_cmd(32'h3001, 32'd1); tick();
    set_cmd(32'h3002, 32'd1); exec_ready = 1; tick();
    chk("t3_pushpop_count", {29'd0, qcount}, 2);
    chk("t3_run", {31'd0, busy}, 1);
    exec_ready = 0; set_cmd(32'h3003, 32'd1); tick(); cmd_valid = 0;
    chk("t3_count3", {29'd0, qcount}, 3);
    flush = 1; tick(); flush = 0;
    chk("t3_flush_count", {29'd0, qcount}, 0);
    chk("t3_still_run", {31'd0, busy}, 1);
    layer_done = 1; tick(); layer_done = 0;
    chk("t3_irq", {31'd0, irq}, 1);
    chk("t3_layers", layers_done, 6);
    chk("t3_idle", {31'd0, busy}, 0);

    // flush during ISSUE: handshake wins, then flush without handshake aborts
    set_cmd(32'h4000, 32'd2); cmd_valid = 1; tick(); cmd_valid = 0;
    tick();
    chk("t4_issue", {31'd0, exec_valid}, 1);
    chk("t4_base", base, 32'h4000);
    flush = 1; exec_ready = 1; tick(); flush = 0; exec_ready = 0;
    chk("t4_hs_wins", {31'd0, busy & ~exec_valid}, 1);
    layer_done = 1; tick(); layer_done = 0;
    chk("t4_layers", layers_done, 7);
    set_cmd(32'h4100, 32'd2); cmd_valid = 1; tick(); cmd_valid = 0;
    tick();
    flush = 1; tick(); flush = 0;
    chk("t4_abort_valid", {31'd0, exec_valid}, 0);
    chk("t4_abort_busy", {31'd0, busy}, 0);
    tick();
    chk("t4_abort_stay", {31'd0, exec_valid}, 0);

    // watchdog expiry and clear
    set_cmd(32'h5000, 32'd3); cmd_valid = 1; exec_ready = 1; tick(); cmd_valid = 0;
    tick(); tick();
    chk("t5_run", {31'd0, busy}, 1);
    set_cmd(32'h5100, 32'd3); cmd_valid = 1; tick(); cmd_valid = 0;
    chk("t5_count1", {29'd0, qcount}, 1);
    repeat (14) tick();
    chk("t5_no_err_yet", {31'd0, error}, 0);
    tick();
    chk("t5_err", {31'd0, error}, 1);
    chk("t5_ready0", {31'd0, cmd_ready}, 0);
    chk("t5_valid0", {31'd0, exec_valid}, 0);
    chk("t5_count_kept", {29'd0, qcount}, 1);
    clear_error = 1; tick(); clear_error = 0;
    chk("t5_cleared", {31'd0, error}, 0);
    chk("t5_count0", {29'd0, qcount}, 0);
    chk("t5_ready1", {31'd0, cmd_ready}, 1);
    tick();
    chk("t5_idle", {31'd0, exec_valid}, 0);

    // done exactly at expiry wins
    set_cmd(32'h6000, 32'd4); cmd_valid = 1; tick(); cmd_valid = 0;
    tick(); tick();
    repeat (15) tick();
    layer_done = 1; tick(); layer_done = 0;
    chk("t6_no_err", {31'd0, error}, 0);
    chk("t6_irq", {31'd0, irq}, 1);
    chk("t6_layers", layers_done, 8);

    // asynchronous reset mid-RUN with two queued
    set_cmd(32'h7000, 32'd5); cmd_valid = 1; tick();
    set_cmd(32'h7001, 32'd5); tick();
    set_cmd(32'h7002, 32'd5); tick(); cmd_valid = 0;
    chk("t7_count2", {29'd0, qcount}, 2);
    chk("t7_run", {31'd0, busy & ~exec_valid}, 1);
    rst_n = 0; #1;
    chk_reset("t7_async");
    tick();
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_npu_layer_scheduler.md
# hs_npu_layer_scheduler

Queues layer descriptors written by the CPU and issues them one at a time to the NPU core over its exec valid/ready handshake. It sits between the CPU register interface and the NPU top level. The scheduler holds each layer's configuration stable while the layer is issued, waits for the layer to complete, and then issues the next queued layer back-to-back. It also provides layer counting, a drain interrupt and a per-layer watchdog.

## Interface
Parameters:
- QUEUE_DEPTH, 4: descriptor queue entries; must be a power of 2, ≥2.
- TIMEOUT_CYCLES, 65536: watchdog limit in cycles per layer; 0 disables the watchdog.

Ports (uword = 32-bit, from hs_npu_pkg):
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  CPU presents a descriptor.
- cmd_ready_o  out  1  queue can accept; equals !full && state!=ERROR.
- cmd_num_input_rows_i, cmd_num_input_columns_i, cmd_num_weight_rows_i, cmd_num_weight_columns_i  in  uword each  matrix dimensions.
- cmd_reuse_inputs_i, cmd_reuse_weights_i, cmd_save_outputs_i, cmd_use_bias_i, cmd_use_sum_i, cmd_activation_select_i  in  1 each  layer flags.
- cmd_shift_amount_i, cmd_base_address_i, cmd_result_address_i  in  uword each  shift and addresses.
- exec_valid_o  out  1  descriptor offered to the NPU.
- exec_ready_i  in  1  NPU accepts.
- num_input_rows_o … result_address_o  out  same widths  one output per cmd_* field; driven from the queue head.
- layer_done_i  in  1  one-cycle pulse from the NPU when the running layer finishes.
- flush_i  in  1  discard all queued (not yet issued) descriptors.
- clear_error_i  in  1  leave ERROR.
- busy_o  out  1  state is ISSUE or RUN.
- queue_count_o  out  $clog2(QUEUE_DEPTH)+1  number of queued entries.
- layers_done_o  out  uword  count of completed layers; wraps modulo 2^32.
- irq_o  out  1  one-cycle pulse when the last queued layer completes.
- error_o  out  1  high in ERROR.

## Operation
- Queue: circular FIFO, QUEUE_DEPTH entries of the full descriptor.
  - Push on cmd_valid_i && cmd_ready_o.
  - Pop on exec_valid_o && exec_ready_i.
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
- FSM states:
  - IDLE: exec_valid_o=0. If count>0, go to ISSUE.
  - ISSUE: exec_valid_o=1, with fields taken from the head entry and held stable until the handshake. On the handshake, pop and go to RUN.
  - RUN: exec_valid_o=0; the watchdog counts.
    - On layer_done_i: layers_done_o+1. If count>0, go to ISSUE; otherwise pulse irq_o and go to IDLE.
  - ERROR: entered on watchdog expiry. exec_valid_o=0, cmd_ready_o=0, error_o=1. On clear_error_i, empty the queue and go to IDLE.
- Watchdog:
  - Counter cleared on entry to RUN.
  - Expires when it reaches TIMEOUT_CYCLES-1 without layer_done_i.
  - If layer_done_i coincides with expiry, done wins (normal completion).
- flush_i:
  - Empties the queue (count=0) next cycle and overrides a same-cycle push.
  - Does not affect a layer in RUN.
  - In ISSUE, flush_i aborts the offer: go to IDLE, unless the handshake completes in the same cycle, in which case the handshake wins and the state goes to RUN.
- layer_done_i outside RUN is ignored.
- Output fields are don't-care while exec_valid_o=0, but must not change while exec_valid_o=1.

## Timing
- Reset values:
  - exec_valid_o=0, cmd_ready_o=1, busy_o=0, irq_o=0, error_o=0.
  - queue_count_o=0, layers_done_o=0.
  - All descriptor outputs 0; state IDLE.
- Push accepted at edge N with the queue empty and state IDLE: exec_valid_o rises after edge N+1 (queue write, then FSM transition).
- Handshake at edge M: exec_valid_o=0 and busy_o=1 after M.
- layer_done_i sampled at edge D:
  - With the queue non-empty, exec_valid_o=1 after D, i.e. back-to-back issue with no idle cycle.
  - With the queue empty, irq_o=1 for the single cycle after D, and busy_o=0.
- queue_count_o and layers_done_o are registered; they update the cycle after the event.
- Reset asserted mid-layer returns all state to the reset values asynchronously; the queue contents are lost.

## Test plan
- Push one descriptor (rows=8, cols=8, base=0x1000), exec_ready_i=1 → exec_valid_o for exactly 1 cycle with base_address_o=0x1000; pulse layer_done_i → layers_done_o=1, irq_o one pulse.
- Push 4 descriptors, exec_ready_i held 0 → cmd_ready_o=0 at count=4, and head fields stay stable; release exec_ready_i → layers issue in push order, with back-to-back issue after each done, and irq_o only after the 4th done.
- Same-cycle push and pop at count=2 → count stays 2; push at count=4 with a same-cycle pop → push refused.
- TIMEOUT_CYCLES=16, no layer_done_i → error_o=1 at cycle 16 after the handshake, cmd_ready_o=0; clear_error_i → IDLE, count=0; done arriving exactly at expiry → no error.
- With 3 queued and 1 running, assert flush_i → count=0 next cycle, the running layer completes, and irq_o pulses; flush during ISSUE with exec_ready_i=1 → the layer issues.
- Assert rst_n low mid-RUN with count=2 → all outputs return to their reset values immediately.
